ex_branch_redirect_ctrl: RTL and testbench
==========================================

Name: ex_branch_redirect_ctrl

Overview:
Sequences the front-end response to a taken branch or jump from the execute-stage branch unit. It captures the registered `do_jump`/`jump_pc` pulse, drives a timed pipeline flush, and hands the target PC to fetch with a valid/ready handshake. It also buffers the r63 link value and arbitrates it onto the shared register writeback port. It holds dispatch until the redirect and the link writeback are both complete.

Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush` is asserted before the redirect is offered; legal range 1..15.
- CNT_W, 32, width of the statistics counters (used only with REDIRECT_STATS_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- do_jump  in  1  one-cycle taken-branch pulse from the branch unit
- jump_pc  in  64  branch target, valid with do_jump
- r63  in  64  link value, valid with r63_update
- r63_update  in  1  link write request, qualified by do_jump
- stall  in  1  commit stall; freezes the flush counter
- flush  out  1  kill all younger in-flight instructions
- redirect_valid  out  1  target PC offered to fetch
- redirect_pc  out  64  target PC, bit0 forced to 0
- redirect_ready  in  1  fetch accepts the redirect
- wb_req  out  1  link writeback request
- wb_addr  out  6  writeback register index, constant 63
- wb_data  out  64  link value
- wb_gnt  in  1  writeback port granted this cycle
- dispatch_hold  out  1  block dispatch
- taken_count  out  CNT_W  statistics
- link_count  out  CNT_W  statistics
- dropped_count  out  CNT_W  statistics

Behaviour:
- Reset (async, rst_n=0) clears all state and outputs:
  - FSM goes to IDLE.
  - flush, redirect_valid, wb_req and the counters are 0.
  - redirect_pc and wb_data are 64'h0.
  - wb_addr is 6'd63 at all times.
- Reset mid-operation abandons any pending redirect or writeback; nothing is replayed.
- FSM states:
  - IDLE:
    - do_jump=1 captures `{jump_pc[63:1],1'b0}` into the target register and goes to FLUSH, with the counter loaded to FLUSH_CYCLES.
    - If r63_update=1 in the same cycle, r63 is captured into the link buffer and link_pending is set.
    - r63_update without do_jump is ignored.
  - FLUSH:
    - flush=1.
    - The counter decrements each cycle that stall=0 and holds while stall=1.
    - When the counter reaches 1 with stall=0, the next state is REDIRECT.
  - REDIRECT:
    - flush=0, redirect_valid=1, redirect_pc = target; redirect_pc is held stable until accepted.
    - On redirect_valid & redirect_ready: go to WAIT_LINK if link_pending, else IDLE.
    - stall has no effect on the handshake.
  - WAIT_LINK: remain until link_pending clears, then go to IDLE.
- Latency:
  - do_jump at cycle N gives flush during N+1 .. N+FLUSH_CYCLES.
  - redirect_valid rises at N+FLUSH_CYCLES+1.
  - With redirect_ready tied high, the FSM is back in IDLE at N+FLUSH_CYCLES+2.
- Link writeback runs independently of the FSM from capture:
  - wb_req = link_pending; wb_data = link buffer.
  - link_pending clears on wb_req & wb_gnt.
  - Grant may arrive in any state, including the capture cycle+1.
- dispatch_hold = do_jump | (state != IDLE) | link_pending. This is combinational so that the pulse cycle itself blocks dispatch.
- do_jump while not IDLE:
  - It comes from a younger instruction already being flushed, so it is ignored.
  - The target and link buffer are not overwritten, and dropped_count increments.
- Simultaneous redirect handshake and wb_gnt in REDIRECT: both complete, and the next state is IDLE.

Optional Feature:
- Macro: REDIRECT_STATS_EN.
- Defined:
  - taken_count increments on every accepted do_jump (IDLE capture).
  - link_count increments on every wb_req & wb_gnt.
  - dropped_count increments on every ignored do_jump.
  - All counters saturate at all-ones and never wrap.
- Undefined: the three count outputs are tied to 0, and no counter flops are synthesized.

Decomposition:
- Shared package (raisin64 pkg) holds:
  - the FSM state enum (IDLE, FLUSH, REDIRECT, WAIT_LINK; 2-bit encoding);
  - LINK_REG = 6'd63;
  - PC_W = 64.
- One natural sub-module: `redirect_sat_counter`, a parameterized CNT_W saturating incrementer with async reset. It is instantiated three times under REDIRECT_STATS_EN.

Test Plan:
- Plain branch:
  - Stimulus: FLUSH_CYCLES=2; do_jump=1, jump_pc=64'h1000, r63_update=0, redirect_ready=1.
  - Response: flush high 2 cycles; redirect_valid with pc 64'h1000 one cycle; wb_req never asserts; dispatch_hold low after 4 cycles.
- Jump-and-link with delayed grant:
  - Stimulus: jump_pc=64'h2003, r63=64'h0ABC, r63_update=1; wb_gnt withheld for 6 cycles.
  - Response: redirect_pc=64'h2002; FSM sits in WAIT_LINK; wb_req held with wb_addr=63, wb_data=64'h0ABC; dispatch_hold drops the cycle after the grant.
- Stall freeze:
  - Stimulus: stall=1 for 3 cycles during FLUSH.
  - Response: flush lasts FLUSH_CYCLES+3 cycles; redirect timing shifts by exactly 3.
- Back-pressure:
  - Stimulus: redirect_ready=0 for 5 cycles.
  - Response: redirect_valid and redirect_pc stable all 5 cycles; a second do_jump with pc 64'h9000 mid-flush is ignored; the target remains the first pc; dropped_count=1.
- Reset mid-operation:
  - Stimulus: rst_n low during REDIRECT with link pending.
  - Response: all outputs 0 immediately (asynchronous); after release, IDLE; no wb_req.
- Saturation (macro on):
  - Stimulus: CNT_W=4; 17 accepted branches.
  - Response: taken_count stops at 4'hF.

Source files
------------

// File: rtl/ex_branch_redirect_ctrl_pkg.sv
// Shared types and constants for the execute-stage branch redirect controller.
package ex_branch_redirect_ctrl_pkg;

   localparam int unsigned PC_W       = 64;
   localparam int unsigned REG_IDX_W  = 6;
   localparam int unsigned FLUSH_CNT_W = 4;

   localparam logic [REG_IDX_W-1:0] LINK_REG = 6'd63;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FLUSH     = 2'd1,
      ST_REDIRECT  = 2'd2,
      ST_WAIT_LINK = 2'd3
   } redirect_state_e;

endpackage

// File: rtl/ex_branch_redirect_ctrl_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module redirect_sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ex_branch_redirect_ctrl.sv
// Taken-branch redirect sequencer: timed flush, fetch redirect handshake, r63 link writeback.
// Optional statistics counters are built when REDIRECT_STATS_EN is defined.
module ex_branch_redirect_ctrl
   import ex_branch_redirect_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 do_jump,
   input  logic [PC_W-1:0]      jump_pc,
   input  logic [PC_W-1:0]      r63,
   input  logic                 r63_update,
   input  logic                 stall,
   output logic                 flush,
   output logic                 redirect_valid,
   output logic [PC_W-1:0]      redirect_pc,
   input  logic                 redirect_ready,
   output logic                 wb_req,
   output logic [REG_IDX_W-1:0] wb_addr,
   output logic [PC_W-1:0]      wb_data,
   input  logic                 wb_gnt,
   output logic                 dispatch_hold,
   output logic [CNT_W-1:0]     taken_count,
   output logic [CNT_W-1:0]     link_count,
   output logic [CNT_W-1:0]     dropped_count
);

   redirect_state_e        state_q, state_d;
   logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
   logic [PC_W-1:0]        target_q, target_d;
   logic [PC_W-1:0]        link_data_q, link_data_d;
   logic                   link_pending_q, link_pending_d;
   logic                   flush_q, flush_d;
   logic                   redirect_valid_q, redirect_valid_d;
   logic                   link_fire;

   assign link_fire = link_pending_q & wb_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus target / link capture; link writeback runs beside the FSM.
   always_comb begin
      state_d        = state_q;
      fcnt_d         = fcnt_q;
      target_d       = target_q;
      link_data_d    = link_data_q;
      link_pending_d = link_pending_q;
      if (link_fire) begin
         link_pending_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (do_jump) begin
               target_d = jump_pc & ~PC_W'(1);
               fcnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES);
               state_d  = ST_FLUSH;
               if (r63_update) begin
                  link_data_d    = r63;
                  link_pending_d = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            if (!stall) begin
               if (fcnt_q <= FLUSH_CNT_W'(1)) begin
                  state_d = ST_REDIRECT;
               end else begin
                  fcnt_d = fcnt_q - FLUSH_CNT_W'(1);
               end
            end
         end
         ST_REDIRECT: begin
            if (redirect_valid_q && redirect_ready) begin
               state_d = link_pending_d ? ST_WAIT_LINK : ST_IDLE;
            end
         end
         ST_WAIT_LINK: begin
            if (!link_pending_d) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the next state so they leave flops aligned with the state.
   always_comb begin
      flush_d          = 1'b0;
      redirect_valid_d = 1'b0;
      flush_d          = (state_d == ST_FLUSH);
      redirect_valid_d = (state_d == ST_REDIRECT);
      dispatch_hold    = do_jump | (state_q != ST_IDLE) | link_pending_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q           <= '0;
         target_q         <= '0;
         link_data_q      <= '0;
         link_pending_q   <= 1'b0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
      end else begin
         fcnt_q           <= fcnt_d;
         target_q         <= target_d;
         link_data_q      <= link_data_d;
         link_pending_q   <= link_pending_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
      end
   end

   assign flush          = flush_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = target_q;
   assign wb_req         = link_pending_q;
   assign wb_addr        = LINK_REG;
   assign wb_data        = link_data_q;

`ifdef REDIRECT_STATS_EN
   logic taken_inc;
   logic drop_inc;

   assign taken_inc = do_jump & (state_q == ST_IDLE);
   assign drop_inc  = do_jump & (state_q != ST_IDLE);

   redirect_sat_counter #(.W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (taken_inc),
      .count (taken_count)
   );

   redirect_sat_counter #(.W(CNT_W)) u_link_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (link_fire),
      .count (link_count)
   );

   redirect_sat_counter #(.W(CNT_W)) u_dropped_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (drop_inc),
      .count (dropped_count)
   );
`else
   assign taken_count   = '0;
   assign link_count    = '0;
   assign dropped_count = '0;
`endif

endmodule

// File: tb/tb_ex_branch_redirect_ctrl.sv
// Directed bench for ex_branch_redirect_ctrl; count expectations follow REDIRECT_STATS_EN.
module tb_ex_branch_redirect_ctrl;

   localparam int unsigned CW = 4;
`ifdef REDIRECT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          do_jump;
   logic [63:0]   jump_pc;
   logic [63:0]   r63;
   logic          r63_update;
   logic          stall;
   logic          flush;
   logic          redirect_valid;
   logic [63:0]   redirect_pc;
   logic          redirect_ready;
   logic          wb_req;
   logic [5:0]    wb_addr;
   logic [63:0]   wb_data;
   logic          wb_gnt;
   logic          dispatch_hold;
   logic [CW-1:0] taken_count;
   logic [CW-1:0] link_count;
   logic [CW-1:0] dropped_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .do_jump        (do_jump),
      .jump_pc        (jump_pc),
      .r63            (r63),
      .r63_update     (r63_update),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .wb_req         (wb_req),
      .wb_addr        (wb_addr),
      .wb_data        (wb_data),
      .wb_gnt         (wb_gnt),
      .dispatch_hold  (dispatch_hold),
      .taken_count    (taken_count),
      .link_count     (link_count),
      .dropped_count  (dropped_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] exp_cnt(input int v);
      return STATS ? CW'(v) : '0;
   endfunction

   task automatic step();
      @(negedge clk);
      do_jump    = 1'b0;
      r63_update = 1'b0;
   endtask

   task automatic jump(input logic [63:0] pc, input logic lnk, input logic [63:0] lv);
      do_jump    = 1'b1;
      jump_pc    = pc;
      r63_update = lnk;
      r63        = lv;
   endtask

   initial begin
      rst_n = 1'b0; do_jump = 1'b0; jump_pc = '0; r63 = '0; r63_update = 1'b0;
      stall = 1'b0; redirect_ready = 1'b0; wb_gnt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_flush", 64'(flush), 64'd0);
      check("rst_rvalid", 64'(redirect_valid), 64'd0);
      check("rst_rpc", redirect_pc, 64'd0);
      check("rst_wbreq", 64'(wb_req), 64'd0);
      check("rst_wbdata", wb_data, 64'd0);
      check("rst_wbaddr", 64'(wb_addr), 64'd63);
      check("rst_taken", 64'(taken_count), 64'd0);
      rst_n = 1'b1;
      step();

      // r63_update alone is ignored
      r63_update = 1'b1; r63 = 64'hDEAD;
      step();
      check("stray_link_wbreq", 64'(wb_req), 64'd0);
      check("stray_link_hold", 64'(dispatch_hold), 64'd0);

      // plain branch
      redirect_ready = 1'b1;
      jump(64'h1000, 1'b0, 64'd0);
      #1 check("t1_hold_pulse", 64'(dispatch_hold), 64'd1);
      step();
      check("t1_flush1", 64'(flush), 64'd1);
      check("t1_rv_n1", 64'(redirect_valid), 64'd0);
      step();
      check("t1_flush2", 64'(flush), 64'd1);
      step();
      check("t1_flush_off", 64'(flush), 64'd0);
      check("t1_rv", 64'(redirect_valid), 64'd1);
      check("t1_rpc", redirect_pc, 64'h1000);
      check("t1_wbreq", 64'(wb_req), 64'd0);
      step();
      check("t1_rv_off", 64'(redirect_valid), 64'd0);
      check("t1_hold_off", 64'(dispatch_hold), 64'd0);

      // jump-and-link, grant withheld 6 cycles
      jump(64'h2003, 1'b1, 64'h0ABC);
      step();
      check("t2_wbreq", 64'(wb_req), 64'd1);
      check("t2_wbaddr", 64'(wb_addr), 64'd63);
      check("t2_wbdata", wb_data, 64'h0ABC);
      check("t2_flush", 64'(flush), 64'd1);
      step();
      step();
      check("t2_rv", 64'(redirect_valid), 64'd1);
      check("t2_rpc", redirect_pc, 64'h2002);
      step();
      check("t2_waitlink_rv", 64'(redirect_valid), 64'd0);
      check("t2_waitlink_hold", 64'(dispatch_hold), 64'd1);
      check("t2_waitlink_wbreq", 64'(wb_req), 64'd1);
      step();
      step();
      check("t2_wbreq_n6", 64'(wb_req), 64'd1);
      check("t2_wbdata_n6", wb_data, 64'h0ABC);
      step();
      wb_gnt = 1'b1;
      #1 check("t2_hold_gnt", 64'(dispatch_hold), 64'd1);
      step();
      wb_gnt = 1'b0;
      check("t2_wbreq_done", 64'(wb_req), 64'd0);
      check("t2_hold_done", 64'(dispatch_hold), 64'd0);
      check("t2_link_count", 64'(link_count), 64'(exp_cnt(1)));

      // stall freezes the flush counter for 3 cycles
      jump(64'h3000, 1'b0, 64'd0);
      step();
      check("t3_flush_n1", 64'(flush), 64'd1);
      stall = 1'b1;
      step();
      check("t3_flush_n2", 64'(flush), 64'd1);
      step();
      check("t3_flush_n3", 64'(flush), 64'd1);
      step();
      check("t3_flush_n4", 64'(flush), 64'd1);
      stall = 1'b0;
      step();
      check("t3_flush_n5", 64'(flush), 64'd1);
      check("t3_rv_n5", 64'(redirect_valid), 64'd0);
      step();
      check("t3_flush_n6", 64'(flush), 64'd0);
      check("t3_rv_n6", 64'(redirect_valid), 64'd1);
      check("t3_rpc", redirect_pc, 64'h3000);
      step();
      check("t3_hold_off", 64'(dispatch_hold), 64'd0);

      // back-pressure plus an ignored younger jump
      redirect_ready = 1'b0;
      jump(64'h5000, 1'b0, 64'd0);
      step();
      check("t4_flush", 64'(flush), 64'd1);
      do_jump = 1'b1; jump_pc = 64'h9000;
      step();
      check("t4_flush2", 64'(flush), 64'd1);
      step();
      for (int i = 0; i < 5; i++) begin
         check("t4_rv_stable", 64'(redirect_valid), 64'd1);
         check("t4_rpc_stable", redirect_pc, 64'h5000);
         if (i < 4) step();
      end
      redirect_ready = 1'b1;
      step();
      check("t4_rv_off", 64'(redirect_valid), 64'd0);
      check("t4_hold_off", 64'(dispatch_hold), 64'd0);
      check("t4_dropped", 64'(dropped_count), 64'(exp_cnt(1)));
      check("t4_taken", 64'(taken_count), 64'(exp_cnt(4)));

      // redirect handshake and link grant in the same cycle
      redirect_ready = 1'b0;
      jump(64'h6000, 1'b1, 64'h77);
      step();
      step();
      step();
      check("t5_rv", 64'(redirect_valid), 64'd1);
      check("t5_wbreq", 64'(wb_req), 64'd1);
      redirect_ready = 1'b1; wb_gnt = 1'b1;
      step();
      wb_gnt = 1'b0;
      check("t5_rv_off", 64'(redirect_valid), 64'd0);
      check("t5_wbreq_off", 64'(wb_req), 64'd0);
      check("t5_hold_off", 64'(dispatch_hold), 64'd0);
      check("t5_link_count", 64'(link_count), 64'(exp_cnt(2)));

      // asynchronous reset during REDIRECT with link pending
      redirect_ready = 1'b0;
      jump(64'h7000, 1'b1, 64'h55);
      step();
      step();
      step();
      check("t6_rv_pre", 64'(redirect_valid), 64'd1);
      check("t6_wbreq_pre", 64'(wb_req), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_rv", 64'(redirect_valid), 64'd0);
      check("t6_rst_rpc", redirect_pc, 64'd0);
      check("t6_rst_wbreq", 64'(wb_req), 64'd0);
      check("t6_rst_wbdata", wb_data, 64'd0);
      check("t6_rst_flush", 64'(flush), 64'd0);
      check("t6_rst_taken", 64'(taken_count), 64'd0);
      check("t6_rst_hold", 64'(dispatch_hold), 64'd0);
      step();
      rst_n = 1'b1;
      redirect_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t6_post_rv", 64'(redirect_valid), 64'd0);
         check("t6_post_wbreq", 64'(wb_req), 64'd0);
         check("t6_post_hold", 64'(dispatch_hold), 64'd0);
      end

      // taken_count saturation over 17 branches
      for (int i = 1; i <= 17; i++) begin
         jump(64'(i * 32'h100), 1'b0, 64'd0);
         step();
         step();
         step();
         step();
         if (i == 14) check("t7_taken14", 64'(taken_count), 64'(exp_cnt(14)));
      end
      check("t7_taken_sat", 64'(taken_count), 64'(exp_cnt(15)));
      check("t7_dropped", 64'(dropped_count), 64'd0);
      check("t7_hold_off", 64'(dispatch_hold), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
